fp_hazard_controller: RTL

FP_HAZARD_CONTROLLER -- requirements
Module: fp_hazard_controller

---
 rtl/fp_hazard_controller_pkg.sv | 30 +++
 rtl/load_use_detect.sv | 17 +
 rtl/fp_hazard_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/fp_hazard_controller_pkg.sv
// rtl/fp_hazard_controller_pkg.sv - shared pipeline types: FSM states, opcodes, FP wait default
package fp_hazard_controller_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    FP_WAIT = 1'b1
  } fp_state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_FP   = 6'd17;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_BEQ  = 6'd4;

  localparam int MAX_WAIT_DEFAULT = 15;

  // True when the opcode reads rt as a source; ADDI and LW write rt instead.
  function automatic logic reads_rt(input logic [5:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_R, OP_FP, OP_SW, OP_BEQ: r = 1'b1;
      OP_ADDI, OP_LW:             r = 1'b0;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use hazard comparator between ID and a load in EX
module load_use_detect
  import fp_hazard_controller_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [5:0] id_opcode,
  output logic       hazard
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || ((ex_rt == id_rt) && reads_rt(id_opcode)));

endmodule

// File: rtl/fp_hazard_controller.sv
// rtl/fp_hazard_controller.sv - FP adder stall FSM with optional load-use stall (LOAD_USE_HAZARD_EN)
module fp_hazard_controller
  import fp_hazard_controller_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_fp,
  input  logic       fp_done,
  output logic       fp_start,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_hold,
  output logic       exmem_bubble,
  output logic       control_mux_select,
  output logic       fp_timeout
);

  localparam logic [3:0] LAST_WAIT = 4'(MAX_WAIT - 1);

  fp_state_t  state_q, state_d;
  logic [3:0] wait_cnt, wait_cnt_d;
  logic       fp_stall;
  logic       timeout_set;
  logic       load_use;

`ifdef LOAD_USE_HAZARD_EN
  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_opcode   (id_opcode),
    .hazard      (load_use)
  );
`else
  logic unused_load_use_inputs;
  assign unused_load_use_inputs = ^{ex_mem_read, ex_rt, id_rs, id_rt, id_opcode};
  assign load_use = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt   <= 4'd0;
      fp_timeout <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_cnt_d;
      if (timeout_set) begin
        fp_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt;
    fp_start    = 1'b0;
    fp_stall    = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_fp) begin
          fp_start   = 1'b1;
          fp_stall   = 1'b1;
          state_d    = FP_WAIT;
          wait_cnt_d = 4'd0;
        end
      end
      FP_WAIT: begin
        wait_cnt_d = wait_cnt + 4'd1;
        if (fp_done) begin
          state_d = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          // This cycle's increment reaches MAX_WAIT: give up and let the pipe move.
          timeout_set = 1'b1;
          state_d     = IDLE;
        end else begin
          fp_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FP stall freezes ID/EX; load-use only injects a bubble through the control mux.
  always_comb begin
    pc_write           = 1'b1;
    ifid_write         = 1'b1;
    idex_hold          = 1'b0;
    exmem_bubble       = 1'b0;
    control_mux_select = 1'b0;
    if (fp_stall) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_hold    = 1'b1;
      exmem_bubble = 1'b1;
    end else if (load_use) begin
      pc_write           = 1'b0;
      ifid_write         = 1'b0;
      control_mux_select = 1'b1;
    end
  end

endmodule
